// File: rtl/sccb_slave.sv
// sccb_slave: camera-side SCCB responder with a 256x8 register file.
// Read path is built only when SCCB_SLAVE_READ_EN is defined.
module sccb_slave #(
    parameter logic [7:0] DEV_ID      = 8'h60,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
`ifdef SCCB_SLAVE_READ_EN
        ST_RDATA,
        ST_RNA,
`endif
        ST_WAIT_STOP
    } state_t;

    localparam logic [6:0] ID7 = DEV_ID[7:1];

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_h_q;
    logic                   sda_h_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start;
    logic                   stop;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  sub_q, sub_d;
    logic        oe_q, oe_d;
    logic        stb_q, stb_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        we;
    logic        rx_phase;
    logic        byte_done;
    logic        id_hit;
    logic [7:0]  regfile_q [256];
`ifdef SCCB_SLAVE_READ_EN
    logic        rd_q, rd_d;
`endif

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_h_q;
    assign scl_fall  = ~scl_s & scl_h_q;
    assign start     = scl_s & sda_h_q & ~sda_s;
    assign stop      = scl_s & ~sda_h_q & sda_s;
    assign rx_phase  = (state_q == ST_ID) ||
                       (state_q == ST_SUB) ||
                       (state_q == ST_WDATA);
    assign byte_done = scl_fall && (cnt_q == 4'd8);
    assign id_hit    = (shift_q[7:1] == ID7);

    // Synchronize the bus pins; reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_h_q    <= 1'b1;
            sda_h_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_h_q    <= scl_s;
            sda_h_q    <= sda_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            sub_q   <= '0;
            oe_q    <= 1'b0;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef SCCB_SLAVE_READ_EN
            rd_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            sub_q   <= sub_d;
            oe_q    <= oe_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef SCCB_SLAVE_READ_EN
            rd_q    <= rd_d;
`endif
        end
    end

    // Register file: cleared by reset, written on the data ACK rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                regfile_q[i] <= '0;
            end
        end else if (we) begin
            regfile_q[sub_q] <= shift_q;
        end
    end

    // Next-state logic: bus conditions first, then per-state bit events.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        sub_d   = sub_q;
        oe_d    = oe_q;
        stb_d   = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        we      = 1'b0;
`ifdef SCCB_SLAVE_READ_EN
        rd_d    = rd_q;
`endif
        if (start) begin
            state_d = ST_ID;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
        end else begin
            if (scl_rise && rx_phase) begin
                shift_d = {shift_q[6:0], sda_s};
                cnt_d   = cnt_q + 4'd1;
            end
            unique case (state_q)
                ST_ID: begin
                    if (byte_done) begin
`ifdef SCCB_SLAVE_READ_EN
                        if (id_hit) begin
                            state_d = ST_ID_ACK;
                            oe_d    = 1'b1;
                            rd_d    = shift_q[0];
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
`else
                        if (id_hit && !shift_q[0]) begin
                            state_d = ST_ID_ACK;
                            oe_d    = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
`endif
                    end
                end
                ST_ID_ACK: begin
                    if (scl_fall) begin
                        cnt_d   = '0;
                        oe_d    = 1'b0;
                        state_d = ST_SUB;
`ifdef SCCB_SLAVE_READ_EN
                        if (rd_q) begin
                            shift_d = regfile_q[sub_q];
                            oe_d    = ~regfile_q[sub_q][7];
                            state_d = ST_RDATA;
                        end
`endif
                    end
                end
                ST_SUB: begin
                    if (byte_done) begin
                        sub_d   = shift_q;
                        oe_d    = 1'b1;
                        state_d = ST_SUB_ACK;
                    end
                end
                ST_SUB_ACK: begin
                    if (scl_fall) begin
                        cnt_d   = '0;
                        oe_d    = 1'b0;
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (byte_done) begin
                        oe_d    = 1'b1;
                        state_d = ST_WDATA_ACK;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_rise) begin
                        we     = 1'b1;
                        stb_d  = 1'b1;
                        addr_d = sub_q;
                        data_d = shift_q;
                    end else if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = ST_WAIT_STOP;
                    end
                end
`ifdef SCCB_SLAVE_READ_EN
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (byte_done) begin
                        oe_d    = 1'b0;
                        state_d = ST_RNA;
                    end else if (scl_fall) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end
                end
                ST_RNA: begin
                    if (scl_fall) begin
                        state_d = ST_WAIT_STOP;
                    end
                end
`endif
                ST_IDLE, ST_WAIT_STOP: begin
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = oe_q;
    assign wr_strobe = stb_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign dbg_data  = regfile_q[dbg_addr];
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sccb_slave.sv
// tb_sccb_slave: directed SCCB transactions with a write-strobe
// scoreboard and a register-file model.
`timescale 1ns/1ps
module tb_sccb_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] dbg_addr = 8'h00;
    logic [7:0] dbg_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    logic [7:0]  model [256];

    assign sda_line = sda_m & ~sda_oe;

    sccb_slave #(.DEV_ID(8'h60), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        model[a] = d;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wclk(5);
        scl_m = 1'b1; wclk(10);
        sda_m = 1'b0; wclk(10);
        scl_m = 1'b0; wclk(5);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wclk(5);
        scl_m = 1'b1; wclk(10);
        sda_m = 1'b1; wclk(10);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wclk(5);
        scl_m = 1'b1; wclk(10);
        scl_m = 1'b0; wclk(5);
    endtask

    // Sends a byte; ack=1 when SDA is low mid-way through the 9th bit.
    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wclk(5);
        scl_m = 1'b1; wclk(5);
        ack = ~sda_line;
        wclk(5);
        scl_m = 1'b0; wclk(5);
    endtask

    task automatic read_byte(output logic [7:0] d, output logic na_rel);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wclk(5);
            scl_m = 1'b1; wclk(5);
            d[i] = sda_line;
            wclk(5);
            scl_m = 1'b0; wclk(5);
        end
        sda_m = 1'b1; wclk(5);
        scl_m = 1'b1; wclk(5);
        na_rel = sda_line;
        wclk(5);
        scl_m = 1'b0; wclk(5);
    endtask

    task automatic chk_dbg(input logic [7:0] a);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg[%0h]", a), {24'd0, dbg_data}, {24'd0, model[a]});
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got addr %0h data %0h expected none",
                         wr_addr, wr_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("strobe_addr", {24'd0, wr_addr}, {24'd0, e[15:8]});
                chk("strobe_data", {24'd0, wr_data}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       rel;
        logic [7:0] rd;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;

        // Reset values.
        wclk(3);
        #1;
        chk("rst_sda_oe", {31'd0, sda_oe}, 0);
        chk("rst_strobe", {31'd0, wr_strobe}, 0);
        chk("rst_wr_addr", {24'd0, wr_addr}, 0);
        chk("rst_wr_data", {24'd0, wr_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk_dbg(8'h12);
        rst_n = 1'b1;
        wclk(10);

        // Plain 3-phase write.
        bus_start();
        chk("busy_after_start", {31'd0, busy}, 1);
        write_byte(8'h60, ack); chk("t1_ack_id", {31'd0, ack}, 1);
        write_byte(8'h12, ack); chk("t1_ack_sub", {31'd0, ack}, 1);
        expect_wr(8'h12, 8'h80);
        write_byte(8'h80, ack); chk("t1_ack_data", {31'd0, ack}, 1);
        bus_stop();
        chk("busy_after_stop", {31'd0, busy}, 0);
        chk_dbg(8'h12);

        // Wrong device ID: nothing acknowledged or stored.
        bus_start();
        write_byte(8'h42, ack); chk("t2_nack_id", {31'd0, ack}, 0);
        write_byte(8'h12, ack); chk("t2_nack_sub", {31'd0, ack}, 0);
        write_byte(8'h55, ack); chk("t2_nack_data", {31'd0, ack}, 0);
        bus_stop();
        chk_dbg(8'h12);

        // Write, 2-phase pointer set, then read.
        bus_start();
        write_byte(8'h60, ack);
        write_byte(8'h0A, ack);
        expect_wr(8'h0A, 8'h3C);
        write_byte(8'h3C, ack); chk("t3_ack_data", {31'd0, ack}, 1);
        bus_stop();
        bus_start();
        write_byte(8'h60, ack); chk("t3_ack_id2", {31'd0, ack}, 1);
        write_byte(8'h0A, ack); chk("t3_ack_sub2", {31'd0, ack}, 1);
        bus_stop();
        bus_start();
        write_byte(8'h61, ack);
`ifdef SCCB_SLAVE_READ_EN
        chk("t3_ack_rd_id", {31'd0, ack}, 1);
        read_byte(rd, rel);
        chk("t3_rd_data", {24'd0, rd}, 32'h3C);
        chk("t3_na_released", {31'd0, rel}, 1);
`else
        chk("t3_nack_rd_id", {31'd0, ack}, 0);
`endif
        bus_stop();
        chk("t3_busy", {31'd0, busy}, 0);

        // Fourth byte before STOP is refused.
        bus_start();
        write_byte(8'h60, ack);
        write_byte(8'h20, ack);
        expect_wr(8'h20, 8'h11);
        write_byte(8'h11, ack); chk("t4_ack_data", {31'd0, ack}, 1);
        write_byte(8'h22, ack); chk("t4_nack_4th", {31'd0, ack}, 0);
        bus_stop();
        chk_dbg(8'h20);
        chk_dbg(8'h21);
        chk_dbg(8'h22);

        // Repeated START after the sub-address.
        bus_start();
        write_byte(8'h60, ack);
        write_byte(8'h05, ack); chk("t5_ack_sub", {31'd0, ack}, 1);
        bus_start();
        write_byte(8'h60, ack); chk("t5_ack_id_rs", {31'd0, ack}, 1);
        write_byte(8'h06, ack);
        expect_wr(8'h06, 8'h77);
        write_byte(8'h77, ack); chk("t5_ack_data", {31'd0, ack}, 1);
        bus_stop();
        chk_dbg(8'h05);
        chk_dbg(8'h06);

        // Reset in the middle of a data byte.
        bus_start();
        write_byte(8'h60, ack);
        write_byte(8'h30, ack);
        send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0);
        chk("t6_busy_mid", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sda_oe", {31'd0, sda_oe}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_strobe", {31'd0, wr_strobe}, 0);
        chk("t6_rst_wr_addr", {24'd0, wr_addr}, 0);
        chk("t6_rst_wr_data", {24'd0, wr_data}, 0);
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        wclk(3);
        rst_n = 1'b1;
        wclk(5);
        bus_stop();
        chk("t6_idle", {31'd0, busy}, 0);
        bus_start();
        write_byte(8'h60, ack); chk("t6_ack_id", {31'd0, ack}, 1);
        write_byte(8'h30, ack);
        expect_wr(8'h30, 8'hA5);
        write_byte(8'hA5, ack); chk("t6_ack_data", {31'd0, ack}, 1);
        bus_stop();

        // Whole register file against the model.
        for (int i = 0; i < 256; i++) chk_dbg(i[7:0]);

        wclk(20);
        chk("pending_strobes", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
